// File: rtl/onehot_scan_pkg.sv
// Shared constants and helpers for the one-hot digit scanner:
// 7-segment lookup table, ring phase constants, rotate and legality helpers.
package onehot_scan_pkg;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v == PH0) || (v == PH1) || (v == PH2) || (v == PH3);
  endfunction

endpackage

// File: rtl/onehot_digit_scanner_hex_to_7seg.sv
// Combinational nibble to 7-segment decoder using the shared lookup table.
module hex_to_7seg
  import onehot_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    seg = HEX7[nib];
  end

endmodule

// File: rtl/onehot_digit_scanner.sv
// Time-multiplexes four hex digits onto one 7-segment bus using the phase of
// an external 4-bit one-hot ring counter. Display data is double-buffered and
// swapped at the 1000->0001 wrap; the phase stream is checked for legality
// and rotation order.
// Optional build macro ONEHOT_SCANNER_DEADTIME_EN: blank the anodes for one
// cycle whenever the phase changes, to suppress ghosting.
module onehot_digit_scanner
  import onehot_scan_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           phase,
  input  logic                 load,
  input  logic [15:0]          din,
  output logic [6:0]           seg,
  output logic [3:0]           an,
  output logic                 frame_done,
  output logic                 phase_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [15:0] pending;
  logic [15:0] active;
  logic [3:0]  phase_q;

  logic        legal;
  logic        legal_q;
  logic        wrap;
  logic        order_err;
  logic        err_now;
  logic [15:0] src_word;
  logic [3:0]  nib;
  logic [6:0]  seg_dec;
  logic [3:0]  an_next;

  // Phase legality, wrap detection and order checking
  always_comb begin
    legal     = is_onehot4(phase);
    legal_q   = is_onehot4(phase_q);
    wrap      = (phase_q == PH3) && (phase == PH0);
    order_err = legal && legal_q && (phase != phase_q) && (phase != rotl4(phase_q));
    err_now   = !legal || order_err;
  end

  // Digit select; on wrap digit 0 reads the pending buffer so the new frame
  // shows up without a one-cycle lag
  always_comb begin
    src_word = wrap ? pending : active;
    nib      = 4'h0;
    case (phase)
      PH0:     nib = src_word[3:0];
      PH1:     nib = src_word[7:4];
      PH2:     nib = src_word[11:8];
      PH3:     nib = src_word[15:12];
      default: nib = 4'h0;
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nib (nib),
    .seg (seg_dec)
  );

  // Anode value for a legal phase, with optional dead time on phase change
  always_comb begin
`ifdef ONEHOT_SCANNER_DEADTIME_EN
    an_next = (phase == phase_q) ? phase : 4'b0000;
`else
    an_next = phase;
`endif
  end

  // Registered display outputs, buffers and error tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      active     <= '0;
      phase_q    <= '0;
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
      phase_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      phase_q    <= phase;
      frame_done <= wrap;
      if (load) pending <= din;
      if (wrap) active <= pending;
      if (legal) begin
        seg <= seg_dec;
        an  <= an_next;
      end else begin
        seg <= '0;
        an  <= '0;
      end
      if (err_now) begin
        phase_err <= 1'b1;
        if (err_cnt != {ERR_CNT_W{1'b1}})
          err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_onehot_digit_scanner.sv
// Scoreboard bench for onehot_digit_scanner: the driver pushes hand-computed
// expectations, the monitor pops one per cycle after the clock edge.
// Two instances share the stimulus: default counter width and a 2-bit counter.
module tb_onehot_digit_scanner;

  typedef struct {
    int         vec;
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  phase = 4'b0000;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;

  logic [6:0] seg_a,  seg_b;
  logic [3:0] an_a,   an_b;
  logic       fd_a,   fd_b;
  logic       err_a,  err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   vec_id = 0;

  always #5 clk = ~clk;

  onehot_digit_scanner #(.ERR_CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .phase(phase), .load(load), .din(din),
    .seg(seg_a), .an(an_a), .frame_done(fd_a), .phase_err(err_a), .err_cnt(cnt_a)
  );

  onehot_digit_scanner #(.ERR_CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .phase(phase), .load(load), .din(din),
    .seg(seg_b), .an(an_b), .frame_done(fd_b), .phase_err(err_b), .err_cnt(cnt_b)
  );

  task automatic chk(input string name, input int vec, input logic [15:0] act,
                     input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, vec, act, req);
    end
  endtask

  // One stimulus vector: drive inputs at the falling edge, queue the response
  // expected after the next rising edge
  task automatic step(input logic r, input logic [3:0] ph, input logic ld,
                      input logic [15:0] d, input logic [6:0] e_seg,
                      input logic [3:0] e_an, input logic [3:0] e_an_dt,
                      input logic e_fd, input logic e_err, input logic [7:0] e_cnt);
    exp_t e;
    @(negedge clk);
    reset = r;
    phase = ph;
    load  = ld;
    din   = d;
    e.vec  = vec_id;
    e.seg  = e_seg;
`ifdef ONEHOT_SCANNER_DEADTIME_EN
    e.an   = e_an_dt;
`else
    e.an   = e_an;
`endif
    e.fd   = e_fd;
    e.err  = e_err;
    e.cnt  = e_cnt;
    e.cnt2 = (e_cnt > 8'd3) ? 2'd3 : e_cnt[1:0];
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: outputs are presented every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("seg",        e.vec, {9'd0, seg_a},  {9'd0, e.seg});
        chk("an",         e.vec, {12'd0, an_a},  {12'd0, e.an});
        chk("frame_done", e.vec, {15'd0, fd_a},  {15'd0, e.fd});
        chk("phase_err",  e.vec, {15'd0, err_a}, {15'd0, e.err});
        chk("err_cnt",    e.vec, {8'd0, cnt_a},  {8'd0, e.cnt});
        chk("seg_w2",     e.vec, {9'd0, seg_b},  {9'd0, e.seg});
        chk("an_w2",      e.vec, {12'd0, an_b},  {12'd0, e.an});
        chk("err_cnt_w2", e.vec, {14'd0, cnt_b}, {14'd0, e.cnt2});
      end
    end
  end

  initial begin
    //   rst phase   ld din       seg    an      an_dt   fd err cnt
    step(1, 4'b0001, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 0, 0);
    // first frame, active buffer still zero
    step(0, 4'b0001, 1, 16'h1234, 7'h3F, 4'b0001, 4'b0000, 0, 0, 0);
    step(0, 4'b0010, 0, 16'h0000, 7'h3F, 4'b0010, 4'b0000, 0, 0, 0);
    step(0, 4'b0100, 0, 16'h0000, 7'h3F, 4'b0100, 4'b0000, 0, 0, 0);
    step(0, 4'b1000, 0, 16'h0000, 7'h3F, 4'b1000, 4'b0000, 0, 0, 0);
    // wrap: digit 0 bypasses to the new value 4
    step(0, 4'b0001, 0, 16'h0000, 7'h66, 4'b0001, 4'b0000, 1, 0, 0);
    step(0, 4'b0010, 0, 16'h0000, 7'h4F, 4'b0010, 4'b0000, 0, 0, 0);
    step(0, 4'b0100, 1, 16'hABCD, 7'h5B, 4'b0100, 4'b0000, 0, 0, 0);
    step(0, 4'b1000, 0, 16'h0000, 7'h06, 4'b1000, 4'b0000, 0, 0, 0);
    step(0, 4'b0001, 0, 16'h0000, 7'h5E, 4'b0001, 4'b0000, 1, 0, 0);
    step(0, 4'b0010, 0, 16'h0000, 7'h39, 4'b0010, 4'b0000, 0, 0, 0);
    step(0, 4'b0100, 0, 16'h0000, 7'h7C, 4'b0100, 4'b0000, 0, 0, 0);
    step(0, 4'b1000, 0, 16'h0000, 7'h77, 4'b1000, 4'b0000, 0, 0, 0);
    // dwell of 3 cycles per digit
    for (int i = 0; i < 3; i++)
      step(0, 4'b0001, 0, 16'h0000, 7'h5E, 4'b0001, (i == 0) ? 4'b0000 : 4'b0001, (i == 0), 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 4'b0010, 0, 16'h0000, 7'h39, 4'b0010, (i == 0) ? 4'b0000 : 4'b0010, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 4'b0100, 0, 16'h0000, 7'h7C, 4'b0100, (i == 0) ? 4'b0000 : 4'b0100, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 4'b1000, 0, 16'h0000, 7'h77, 4'b1000, (i == 0) ? 4'b0000 : 4'b1000, 0, 0, 0);
    // load coincident with wrap: old pending goes active, 5678 waits a frame
    step(0, 4'b0001, 1, 16'h5678, 7'h5E, 4'b0001, 4'b0000, 1, 0, 0);
    step(0, 4'b0010, 0, 16'h0000, 7'h39, 4'b0010, 4'b0000, 0, 0, 0);
    step(0, 4'b0100, 0, 16'h0000, 7'h7C, 4'b0100, 4'b0000, 0, 0, 0);
    step(0, 4'b1000, 0, 16'h0000, 7'h77, 4'b1000, 4'b0000, 0, 0, 0);
    step(0, 4'b0001, 0, 16'h0000, 7'h7F, 4'b0001, 4'b0000, 1, 0, 0);
    // two-hot phase for two cycles
    step(0, 4'b0110, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 1, 1);
    step(0, 4'b0110, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 1, 2);
    // legal after illegal: accepted without order error
    step(0, 4'b0001, 0, 16'h0000, 7'h7F, 4'b0001, 4'b0000, 0, 1, 2);
    // skip 0001 -> 0100: order error but digit shown; hold does not count
    step(0, 4'b0100, 0, 16'h0000, 7'h7D, 4'b0100, 4'b0000, 0, 1, 3);
    step(0, 4'b0100, 0, 16'h0000, 7'h7D, 4'b0100, 4'b0100, 0, 1, 3);
    // more illegal patterns: 2-bit counter saturates at 3
    step(0, 4'b0000, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 1, 4);
    step(0, 4'b1111, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 1, 5);
    step(0, 4'b0011, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 1, 6);
    step(0, 4'b1000, 0, 16'h0000, 7'h6D, 4'b1000, 4'b0000, 0, 1, 6);
    step(0, 4'b0001, 0, 16'h0000, 7'h7F, 4'b0001, 4'b0000, 1, 1, 6);
    step(0, 4'b0010, 1, 16'hFFFF, 7'h07, 4'b0010, 4'b0000, 0, 1, 6);
    // reset mid-frame discards pending FFFF
    step(1, 4'b0100, 0, 16'h0000, 7'h00, 4'b0000, 4'b0000, 0, 0, 0);
    step(0, 4'b0100, 0, 16'h0000, 7'h3F, 4'b0100, 4'b0000, 0, 0, 0);
    step(0, 4'b1000, 0, 16'h0000, 7'h3F, 4'b1000, 4'b0000, 0, 0, 0);
    step(0, 4'b0001, 0, 16'h0000, 7'h3F, 4'b0001, 4'b0000, 1, 0, 0);
    step(0, 4'b0010, 0, 16'h0000, 7'h3F, 4'b0010, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
